// File: rtl/timebase_monitor.sv
// timebase_monitor: checks that a one-cycle timebase strobe arrives every
// 2^(dividerSetting+1) clocks, measures each interval and reports lock,
// fault and missed-pulse status. All outputs are registered.
//
// Optional feature: define TIMEBASE_MONITOR_FAULT_COUNTER_EN to add the
// 8-bit saturating faultCount output (FAULT entries plus missed pulses).
//
// state   | meaning
// IDLE    | disabled or invalid setting; waiting for a valid, enabled setup
// ARMED   | waiting for the first pulse to start measuring
// ACQUIRE | measuring intervals, counting consecutive correct ones
// LOCKED  | LOCK_COUNT correct intervals seen; any error drops to FAULT
// FAULT   | lost lock; the next pulse restarts acquisition
module timebase_monitor #(
  parameter int COUNTER_WIDTH = 8,
  parameter int LOCK_COUNT    = 4
) (
  input  logic                     clockIn,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2:0]               dividerSetting,
  input  logic                     timebaseIn,
  output logic                     locked,
  output logic                     fault,
  output logic                     missedPulse,
  output logic [COUNTER_WIDTH-1:0] measuredPeriod,
`ifdef TIMEBASE_MONITOR_FAULT_COUNTER_EN
  output logic                     periodValid,
  output logic [7:0]               faultCount
`else
  output logic                     periodValid
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ACQUIRE,
    S_LOCKED,
    S_FAULT
  } state_t;

  localparam int W = COUNTER_WIDTH;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [3:0]     match_q, match_d;
  logic [3:0]     match_inc;
  logic [W-1:0]   meas_q, meas_d;
  logic [2:0]     setting_q;
  logic           sticky_q, sticky_d;
  logic           locked_q, locked_d;
  logic           fault_q, fault_d;
  logic           miss_q, miss_d;
  logic           pv_q, pv_d;
  logic           setting_valid;
  logic           setting_changed;
  logic           fault_entry;
  logic [W-1:0]   period_c;
  logic [W-1:0]   timeout_c;

  // Expected period and timeout threshold from the divider setting
  always_comb begin
    period_c = '0;
    case (dividerSetting)
      3'd0:    period_c = W'(2);
      3'd1:    period_c = W'(4);
      3'd2:    period_c = W'(8);
      3'd3:    period_c = W'(16);
      3'd4:    period_c = W'(32);
      default: period_c = '0;
    endcase
    timeout_c       = period_c << 1;
    setting_valid   = (dividerSetting <= 3'd4);
    setting_changed = (state_q != S_IDLE) && (dividerSetting != setting_q);
    match_inc       = match_q + 4'd1;
    // interval counter restarts at 1 on a pulse so a k-cycle gap reads k
    if (timebaseIn)
      cnt_d = W'(1);
    else if (cnt_q == {W{1'b1}})
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + W'(1);
  end

  // Next-state, measurement and status decode
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    meas_d   = meas_q;
    sticky_d = sticky_q;
    pv_d     = 1'b0;
    miss_d   = 1'b0;

    if (!enable || !setting_valid) begin
      state_d  = S_IDLE;
      match_d  = '0;
      sticky_d = 1'b0;
    end else if (setting_changed) begin
      // retarget cleanly: no fault, no missed pulse
      state_d  = S_ARMED;
      match_d  = '0;
      sticky_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (timebaseIn) begin
            state_d = S_ACQUIRE;
            match_d = '0;
          end
        end
        S_ACQUIRE: begin
          if (timebaseIn) begin
            pv_d   = 1'b1;
            meas_d = cnt_q;
            if (cnt_q == period_c) begin
              match_d = match_inc;
              if (match_inc == 4'(LOCK_COUNT)) state_d = S_LOCKED;
            end else begin
              match_d = '0;
            end
          end else if (cnt_q == timeout_c) begin
            miss_d  = 1'b1;
            state_d = S_ARMED;
            match_d = '0;
          end
        end
        S_LOCKED: begin
          if (timebaseIn) begin
            pv_d   = 1'b1;
            meas_d = cnt_q;
            if (cnt_q != period_c) state_d = S_FAULT;
          end else if (cnt_q == timeout_c) begin
            miss_d  = 1'b1;
            state_d = S_FAULT;
          end
        end
        S_FAULT: begin
          // recovery pulse is a real interval, so it counts from a cleared tally
          if (timebaseIn) begin
            pv_d   = 1'b1;
            meas_d = cnt_q;
            if (cnt_q == period_c) begin
              match_d = 4'd1;
              state_d = (LOCK_COUNT == 1) ? S_LOCKED : S_ACQUIRE;
            end else begin
              match_d = '0;
              state_d = S_ACQUIRE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    fault_entry = (state_d == S_FAULT) && (state_q != S_FAULT);
    // fault holds through recovery until lock is regained
    if (fault_entry)          sticky_d = 1'b1;
    if (state_d == S_LOCKED)  sticky_d = 1'b0;

    locked_d = (state_d == S_LOCKED);
    fault_d  = sticky_d || (enable && !setting_valid);
  end

  // State and registered outputs
  always_ff @(posedge clockIn or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      match_q   <= '0;
      meas_q    <= '0;
      setting_q <= '0;
      sticky_q  <= 1'b0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
      miss_q    <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      meas_q    <= meas_d;
      setting_q <= dividerSetting;
      sticky_q  <= sticky_d;
      locked_q  <= locked_d;
      fault_q   <= fault_d;
      miss_q    <= miss_d;
      pv_q      <= pv_d;
    end
  end

  assign locked         = locked_q;
  assign fault          = fault_q;
  assign missedPulse    = miss_q;
  assign measuredPeriod = meas_q;
  assign periodValid    = pv_q;

`ifdef TIMEBASE_MONITOR_FAULT_COUNTER_EN
  logic [7:0] fcnt_q, fcnt_d;
  logic [8:0] fcnt_sum;

  // Saturating tally of FAULT entries and missed pulses
  always_comb begin
    fcnt_sum = {1'b0, fcnt_q} + {8'd0, fault_entry} + {8'd0, miss_d};
    if (!enable)
      fcnt_d = '0;
    else if (fcnt_sum > 9'd255)
      fcnt_d = 8'd255;
    else
      fcnt_d = fcnt_sum[7:0];
  end

  // Fault counter register
  always_ff @(posedge clockIn or negedge reset) begin
    if (!reset) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign faultCount = fcnt_q;
`endif

endmodule

// File: tb/tb_timebase_monitor.sv
// Testbench for timebase_monitor: scoreboard of expected measuredPeriod
// values popped on each periodValid, plus per-scenario status checks.
module tb_timebase_monitor;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] dividerSetting;
  logic       timebaseIn;
  logic       locked;
  logic       fault;
  logic       missedPulse;
  logic [7:0] measuredPeriod;
  logic       periodValid;
`ifdef TIMEBASE_MONITOR_FAULT_COUNTER_EN
  logic [7:0] faultCount;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  timebase_monitor #(.COUNTER_WIDTH(8), .LOCK_COUNT(4)) dut (
    .clockIn        (clk),
    .reset          (reset),
    .enable         (enable),
    .dividerSetting (dividerSetting),
    .timebaseIn     (timebaseIn),
    .locked         (locked),
    .fault          (fault),
    .missedPulse    (missedPulse),
    .measuredPeriod (measuredPeriod),
`ifdef TIMEBASE_MONITOR_FAULT_COUNTER_EN
    .periodValid    (periodValid),
    .faultCount     (faultCount)
`else
    .periodValid    (periodValid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every periodValid must match the oldest expected interval
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (periodValid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pv_unexpected: measuredPeriod=%0d, no periodValid required", measuredPeriod);
      end else begin
        e = exp_q.pop_front();
        if (measuredPeriod !== e) begin
          bad++;
          $display("FAIL measured_period: got %0d, expected %0d", measuredPeriod, e);
        end
      end
    end
  end

  task automatic cyc(input logic tb_in);
    timebaseIn = tb_in;
    @(posedge clk);
    #1;
    timebaseIn = 1'b0;
  endtask

  // k-cycle gap ending in a pulse; optionally expect it to be measured
  task automatic gap_pulse(input int k, input bit exp_pv);
    repeat (k - 1) cyc(1'b0);
    if (exp_pv) exp_q.push_back(8'(k));
    cyc(1'b1);
  endtask

  task automatic lock_at(input int p);
    cyc(1'b1);
    repeat (4) gap_pulse(p, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b0; dividerSetting = 3'd1; timebaseIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b, expected 0", locked); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b, expected 0", fault); end
    total++; if (missedPulse !== 1'b0) begin bad++; $display("FAIL rst_missed: got %b, expected 0", missedPulse); end
    total++; if (periodValid !== 1'b0) begin bad++; $display("FAIL rst_pv: got %b, expected 0", periodValid); end
    total++; if (measuredPeriod !== 8'd0) begin bad++; $display("FAIL rst_meas: got %0d, expected 0", measuredPeriod); end
    reset = 1'b1;
    cyc(1'b0);
  endtask

  task automatic test_lock;
    enable = 1'b1; dividerSetting = 3'd1;
    cyc(1'b0);
    cyc(1'b1);
    total++; if (periodValid !== 1'b0) begin bad++; $display("FAIL lock_first_pv: got %b, expected 0", periodValid); end
    exp_q.push_back(8'd4);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    total++; if (periodValid !== 1'b1 || measuredPeriod !== 8'd4)
      begin bad++; $display("FAIL lock_first_meas: pv=%b meas=%0d, expected pv=1 meas=4", periodValid, measuredPeriod); end
    repeat (2) gap_pulse(4, 1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b, expected 0", locked); end
    gap_pulse(4, 1'b1);
    total++; if (locked !== 1'b1 || fault !== 1'b0)
      begin bad++; $display("FAIL lock_locked: locked=%b fault=%b, expected 1/0", locked, fault); end
  endtask

  task automatic test_missing_pulse;
    int early;
    dividerSetting = 3'd2;
    cyc(1'b0);
    total++; if (locked !== 1'b0 || fault !== 1'b0)
      begin bad++; $display("FAIL retarget: locked=%b fault=%b, expected 0/0", locked, fault); end
    lock_at(8);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL miss_locked: got %b, expected 1", locked); end
    early = 0;
    repeat (15) begin
      cyc(1'b0);
      if (missedPulse !== 1'b0) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL miss_early: %0d early strobes, expected 0", early); end
    cyc(1'b0);
    total++; if (missedPulse !== 1'b1 || fault !== 1'b1 || locked !== 1'b0)
      begin bad++; $display("FAIL miss_strobe: missed=%b fault=%b locked=%b, expected 1/1/0", missedPulse, fault, locked); end
    cyc(1'b0);
    total++; if (missedPulse !== 1'b0 || fault !== 1'b1)
      begin bad++; $display("FAIL miss_once: missed=%b fault=%b, expected 0/1", missedPulse, fault); end
  endtask

  task automatic test_wrong_period;
    dividerSetting = 3'd1;
    cyc(1'b0);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL wp_clear: fault=%b, expected 0", fault); end
    lock_at(4);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL wp_locked: got %b, expected 1", locked); end
    gap_pulse(3, 1'b1);
    total++; if (fault !== 1'b1 || locked !== 1'b0 || measuredPeriod !== 8'd3)
      begin bad++; $display("FAIL wp_fault: fault=%b locked=%b meas=%0d, expected 1/0/3", fault, locked, measuredPeriod); end
    repeat (3) gap_pulse(4, 1'b1);
    total++; if (fault !== 1'b1 || locked !== 1'b0)
      begin bad++; $display("FAIL wp_hold: fault=%b locked=%b, expected 1/0", fault, locked); end
    gap_pulse(4, 1'b1);
    total++; if (fault !== 1'b0 || locked !== 1'b1)
      begin bad++; $display("FAIL wp_relock: fault=%b locked=%b, expected 0/1", fault, locked); end
  endtask

  task automatic test_setting_change;
    dividerSetting = 3'd0;
    cyc(1'b0);
    lock_at(2);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sc_locked0: got %b, expected 1", locked); end
    dividerSetting = 3'd4;
    cyc(1'b0);
    total++; if (locked !== 1'b0 || fault !== 1'b0 || missedPulse !== 1'b0)
      begin bad++; $display("FAIL sc_armed: locked=%b fault=%b missed=%b, expected 0/0/0", locked, fault, missedPulse); end
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    repeat (3) gap_pulse(32, 1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL sc_early: got %b, expected 0", locked); end
    gap_pulse(32, 1'b1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sc_relock: got %b, expected 1", locked); end
    // pulse exactly at the timeout point wins and is measured as a mismatch
    gap_pulse(64, 1'b1);
    total++; if (fault !== 1'b1 || locked !== 1'b0 || missedPulse !== 1'b0)
      begin bad++; $display("FAIL sc_coincide: fault=%b locked=%b missed=%b, expected 1/0/0", fault, locked, missedPulse); end
  endtask

`ifdef TIMEBASE_MONITOR_FAULT_COUNTER_EN
  task automatic test_fault_counter;
    dividerSetting = 3'd0;
    cyc(1'b0);
    repeat (300) begin
      cyc(1'b1);
      repeat (4) cyc(1'b0);
    end
    total++; if (faultCount !== 8'd255) begin bad++; $display("FAIL fcnt_sat: got %0d, expected 255", faultCount); end
  endtask
`endif

  task automatic test_invalid_and_reset;
    dividerSetting = 3'd6;
    cyc(1'b0);
    total++; if (fault !== 1'b1 || locked !== 1'b0)
      begin bad++; $display("FAIL inv_fault: fault=%b locked=%b, expected 1/0", fault, locked); end
    repeat (6) gap_pulse(4, 1'b0);
    total++; if (fault !== 1'b1 || locked !== 1'b0)
      begin bad++; $display("FAIL inv_nolock: fault=%b locked=%b, expected 1/0", fault, locked); end
    dividerSetting = 3'd1;
    cyc(1'b0);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL inv_clear: fault=%b, expected 0", fault); end
    lock_at(4);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL rst_pre_locked: got %b, expected 1", locked); end
    #2 reset = 1'b0;
    #1;
    total++; if ({locked, fault, missedPulse, periodValid} !== 4'b0000 || measuredPeriod !== 8'd0)
      begin bad++; $display("FAIL async_rst: l/f/m/pv=%b meas=%0d, expected 0000 0",
                            {locked, fault, missedPulse, periodValid}, measuredPeriod); end
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    lock_at_partial();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reacq_early: got %b, expected 0", locked); end
    gap_pulse(4, 1'b1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL reacq_lock: got %b, expected 1", locked); end
  endtask

  task automatic lock_at_partial;
    cyc(1'b1);
    repeat (3) gap_pulse(4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_missing_pulse();
    test_wrong_period();
    test_setting_change();
`ifdef TIMEBASE_MONITOR_FAULT_COUNTER_EN
    test_fault_counter();
`endif
    test_invalid_and_reset();
    repeat (2) cyc(1'b0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pv_missing: %0d expected measurements never reported, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
